// File: rtl/rgb_pkg.sv
// rtl/rgb_pkg.sv - shared colour constants and arbiter state type for the RGB LED arbiter
package rgb_pkg;

   localparam logic [2:0] OFF   = 3'b000;
   localparam logic [2:0] RED   = 3'b001;
   localparam logic [2:0] GREEN = 3'b010;
   localparam logic [2:0] BLUE  = 3'b100;
   localparam logic [2:0] WHITE = 3'b111;

   typedef enum logic [1:0] {
      IDLE,
      HOLD,
      EXTEND,
      GAP
   } arb_state_t;

endpackage

// File: rtl/rgb_pwm.sv
// rtl/rgb_pwm.sv - free-running PWM brightness stage gating a 3-bit bgr colour onto registered RGB pins
module rgb_pwm
   import rgb_pkg::*;
#(
   parameter int PWM_BITS = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [PWM_BITS-1:0] brightness,
   input  logic [2:0]          color_in,
   input  logic                enable,
   output logic                RGB_R,
   output logic                RGB_G,
   output logic                RGB_B
);

   logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
   logic [2:0]          rgb_q, rgb_d;
   logic                pwm_on;

   always_comb begin
      pwm_cnt_d = pwm_cnt_q + 1'b1;
      // full-scale brightness must never blink for one count per period
      pwm_on    = (brightness == '1) || (pwm_cnt_q < brightness);
      rgb_d     = (enable && pwm_on) ? color_in : OFF;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pwm_cnt_q <= '0;
         rgb_q     <= OFF;
      end else begin
         pwm_cnt_q <= pwm_cnt_d;
         rgb_q     <= rgb_d;
      end
   end

   assign RGB_R = rgb_q[0];
   assign RGB_G = rgb_q[1];
   assign RGB_B = rgb_q[2];

endmodule

// File: rtl/rgb_led_arbiter.sv
// rtl/rgb_led_arbiter.sv - round-robin owner arbitration of one RGB LED with minimum hold time and blank gap
module rgb_led_arbiter
   import rgb_pkg::*;
#(
   parameter int NUM_REQ     = 4,
   parameter int HOLD_CYCLES = 1200000,
   parameter int GAP_CYCLES  = 120000,
   parameter int PWM_BITS    = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_REQ-1:0]   req,
   input  logic [3*NUM_REQ-1:0] req_color,
   input  logic [PWM_BITS-1:0]  brightness,
   output logic [NUM_REQ-1:0]   grant,
   output logic                 busy,
   output logic                 RGB_R,
   output logic                 RGB_G,
   output logic                 RGB_B
);

   localparam int CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
   localparam int CW      = $clog2(CNT_MAX + 1);
   localparam int RW      = $clog2(NUM_REQ);
   localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
   localparam logic [CW-1:0] GAP_LAST  = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
   localparam logic [RW-1:0] RR_LAST   = RW'(NUM_REQ - 1);

   // returns {found, index}: first requester after ptr, wrapping, ptr itself last
   function automatic logic [RW:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                           input logic [RW-1:0]      ptr);
      logic [RW-1:0] idx;
      logic [RW:0]   res;
      idx = ptr;
      res = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = (idx == RR_LAST) ? '0 : idx + 1'b1;
         if (!res[RW] && r[idx]) res = {1'b1, idx};
      end
      return res;
   endfunction

   arb_state_t          state_q, state_d;
   logic [NUM_REQ-1:0]  grant_q, grant_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [RW-1:0]       rr_q, rr_d;
   logic [2:0]          color_q, color_d;

   logic [2:0]          colors [NUM_REQ];
   logic [RW:0]         pick_all, pick_oth;
   logic                owner_req;
   logic                take_en;
   logic [RW-1:0]       take_idx;
   logic                show_d;

   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) colors[i] = req_color[3*i +: 3];
   end

   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      cnt_d     = cnt_q;
      rr_d      = rr_q;
      color_d   = color_q;
      take_en   = 1'b0;
      take_idx  = '0;
      pick_all  = rr_pick(req, rr_q);
      pick_oth  = rr_pick(req & ~grant_q, rr_q);
      owner_req = |(req & grant_q);

      unique case (state_q)
         IDLE: begin
            if (pick_all[RW]) begin
               take_en  = 1'b1;
               take_idx = pick_all[RW-1:0];
            end
         end
         HOLD: begin
            cnt_d = cnt_q + 1'b1;
            if (owner_req) color_d = colors[rr_q];
            if (cnt_q == HOLD_LAST) begin
               if (pick_oth[RW]) begin
                  if (GAP_CYCLES == 0) begin
                     take_en  = 1'b1;
                     take_idx = pick_oth[RW-1:0];
                  end else begin
                     state_d = GAP;
                     grant_d = '0;
                     cnt_d   = '0;
                  end
               end else if (owner_req) begin
                  state_d = EXTEND;
               end else begin
                  state_d = IDLE;
                  grant_d = '0;
               end
            end
         end
         EXTEND: begin
            // a waiting requester outranks the owner releasing in the same cycle
            if (pick_oth[RW]) begin
               if (GAP_CYCLES == 0) begin
                  take_en  = 1'b1;
                  take_idx = pick_oth[RW-1:0];
               end else begin
                  state_d = GAP;
                  grant_d = '0;
                  cnt_d   = '0;
               end
            end else if (!owner_req) begin
               state_d = IDLE;
               grant_d = '0;
            end else begin
               color_d = colors[rr_q];
            end
         end
         GAP: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == GAP_LAST) begin
               if (pick_all[RW]) begin
                  take_en  = 1'b1;
                  take_idx = pick_all[RW-1:0];
               end else begin
                  state_d = IDLE;
               end
            end
         end
      endcase

      if (take_en) begin
         state_d = HOLD;
         grant_d = NUM_REQ'(1) << take_idx;
         cnt_d   = '0;
         rr_d    = take_idx;
         color_d = colors[take_idx];
      end

      show_d = (state_d == HOLD) || (state_d == EXTEND);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         grant_q <= '0;
         cnt_q   <= '0;
         rr_q    <= RR_LAST;
         color_q <= OFF;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         cnt_q   <= cnt_d;
         rr_q    <= rr_d;
         color_q <= color_d;
      end
   end

   assign grant = grant_q;
   assign busy  = (state_q == HOLD) || (state_q == EXTEND);

   // fed from next-state values so the registered pins line up with grant
   rgb_pwm #(
      .PWM_BITS (PWM_BITS)
   ) u_pwm (
      .clk        (clk),
      .rst        (rst),
      .brightness (brightness),
      .color_in   (color_d),
      .enable     (show_d),
      .RGB_R      (RGB_R),
      .RGB_G      (RGB_G),
      .RGB_B      (RGB_B)
   );

endmodule

// File: tb/tb_rgb_led_arbiter.sv
// tb/tb_rgb_led_arbiter.sv - directed self-checking bench for rgb_led_arbiter
module tb_rgb_led_arbiter;
   import rgb_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req;
   logic [11:0] req_color;
   logic [3:0]  brightness;
   logic [3:0]  grant;
   logic        busy;
   logic        RGB_R, RGB_G, RGB_B;
   logic [7:0]  obs;

   int total  = 0;
   int passed = 0;

   always #5 clk = ~clk;

   rgb_led_arbiter #(
      .NUM_REQ     (4),
      .HOLD_CYCLES (8),
      .GAP_CYCLES  (2),
      .PWM_BITS    (4)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req        (req),
      .req_color  (req_color),
      .brightness (brightness),
      .grant      (grant),
      .busy       (busy),
      .RGB_R      (RGB_R),
      .RGB_G      (RGB_G),
      .RGB_B      (RGB_B)
   );

   assign obs = {grant, busy, RGB_B, RGB_G, RGB_R};

   task automatic chk(input string tag, input logic [7:0] o, input logic [7:0] e);
      total = total + 1;
      assert (o === e) passed = passed + 1;
      else $error("FAIL %s observed=%02h expected=%02h", tag, o, e);
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      req = 4'b0000;
      tick(2);
      rst = 1'b0;
   endtask

   initial begin
      logic [2:0] cols [4];
      int n;
      cols[0] = RED;
      cols[1] = GREEN;
      cols[2] = BLUE;
      cols[3] = WHITE;

      rst        = 1'b1;
      req        = 4'b0000;
      req_color  = '0;
      brightness = 4'hF;
      tick(2);
      chk("reset_outputs", obs, 8'h00);
      rst = 1'b0;
      tick(5);
      chk("idle_no_req", obs, 8'h00);

      // single owner held: grant, EXTEND, colour tracking, release
      req_color[2:0] = GREEN;
      req = 4'b0001;
      tick(1);
      chk("t2_grant", obs, {4'b0001, 1'b1, GREEN});
      tick(8);
      chk("t2_extend", obs, {4'b0001, 1'b1, GREEN});
      req_color[2:0] = RED;
      tick(1);
      chk("t2_track", obs, {4'b0001, 1'b1, RED});
      req = 4'b0000;
      tick(1);
      chk("t2_release", obs, 8'h00);

      // one-cycle request: latched colour held for the full hold
      do_reset();
      req_color[2:0] = RED;
      req = 4'b0001;
      tick(1);
      req = 4'b0000;
      chk("t3_first", obs, {4'b0001, 1'b1, RED});
      req_color[2:0] = BLUE;
      tick(7);
      chk("t3_last", obs, {4'b0001, 1'b1, RED});
      tick(1);
      chk("t3_idle", obs, 8'h00);

      // all requesting: rotation with gaps
      do_reset();
      req_color = {WHITE, BLUE, GREEN, RED};
      req = 4'b1111;
      tick(1);
      for (int j = 0; j < 5; j++) begin
         chk($sformatf("t4_first_%0d", j), obs, {4'b0001 << (j % 4), 1'b1, cols[j % 4]});
         tick(7);
         chk($sformatf("t4_last_%0d", j), obs, {4'b0001 << (j % 4), 1'b1, cols[j % 4]});
         tick(1);
         chk($sformatf("t4_gap0_%0d", j), obs, 8'h00);
         tick(1);
         chk($sformatf("t4_gap1_%0d", j), obs, 8'h00);
         tick(1);
      end

      // EXTEND owner drops as another rises: gap wins
      do_reset();
      req_color = {WHITE, BLUE, RED, GREEN};
      req = 4'b0100;
      tick(1);
      chk("t5_grant2", obs, {4'b0100, 1'b1, BLUE});
      tick(8);
      chk("t5_extend", obs, {4'b0100, 1'b1, BLUE});
      req = 4'b0001;
      tick(1);
      chk("t5_gap0", obs, 8'h00);
      tick(1);
      chk("t5_gap1", obs, 8'h00);
      tick(1);
      chk("t5_grant0", obs, {4'b0001, 1'b1, GREEN});
      tick(2);
      rst = 1'b1;
      tick(1);
      chk("mid_hold_reset", obs, 8'h00);
      rst = 1'b0;
      req = 4'b0000;
      tick(1);

      // brightness scaling
      do_reset();
      brightness = 4'h4;
      req_color[2:0] = BLUE;
      req = 4'b0001;
      tick(1);
      n = 0;
      for (int i = 0; i < 16; i++) begin
         if (RGB_B) n++;
         tick(1);
      end
      chk("t6_duty4", 8'(n), 8'd4);
      chk("t6_busy4", {7'b0, busy}, 8'd1);
      brightness = 4'h0;
      n = 0;
      for (int i = 0; i < 16; i++) begin
         tick(1);
         if (RGB_B) n++;
      end
      chk("t6_duty0", 8'(n), 8'd0);
      chk("t6_busy0", {7'b0, busy}, 8'd1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/rgb_led_arbiter.md
Name: rgb_led_arbiter

Overview:
Shares the single on-board RGB LED between NUM_REQ independent colour sources, such as the colour wheel, a status indicator and an alert source.
Arbitration is round-robin with a guaranteed minimum display time per owner and a blank gap between owners, so every source stays visible and the LED never flickers.
The granted colour is brightness-scaled by a shared PWM stage before it drives the RGB pins.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
HOLD_CYCLES, 1200000, minimum clk cycles an owner is displayed (100 ms at 12 MHz); must be >= 1
GAP_CYCLES, 120000, clk cycles the LED is blanked between two different owners; 0 disables the gap
PWM_BITS, 8, width of the brightness control and PWM counter

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous to clk, active-high
req  in  NUM_REQ  per-requester request, level-sensitive
req_color  in  3*NUM_REQ  per-requester colour, bgr encoding (bit0 R, bit1 G, bit2 B), slice i = bits [3i+2:3i]
brightness  in  PWM_BITS  global duty; all-ones = always on, 0 = off
grant  out  NUM_REQ  one-hot current owner; all-zero when no owner
busy  out  1  high when state is HOLD or EXTEND
RGB_R  out  1  red drive, 1 = lit
RGB_G  out  1  green drive, 1 = lit
RGB_B  out  1  blue drive, 1 = lit

Behaviour:
- Reset (rst high at a clk edge) sets:
  - state = IDLE, grant = 0, busy = 0, RGB_* = 0;
  - hold/gap counter = 0, PWM counter = 0, shown colour = 0;
  - rr pointer = NUM_REQ-1, so requester 0 wins the first arbitration.
- Reset mid-operation aborts any grant immediately; outputs are 0 on the cycle after the reset edge.
- Round-robin pick: the first index with req high, searching rr+1 upward and wrapping modulo NUM_REQ. On every new grant, rr := winner.
- IDLE: if any req is high at edge t, then at t+1:
  - grant = winner, state = HOLD, counter = 0;
  - shown colour = winner's req_color sampled at t.
  - If no req is high, stay in IDLE with RGB dark.
- HOLD:
  - counter increments every cycle.
  - While the owner's req is high, shown colour tracks its req_color (1-cycle registered).
  - If the owner drops req, the last colour is latched and the owner is still displayed until the hold expires.
  - Expiry occurs when counter == HOLD_CYCLES-1.
- On expiry, the next state is decided by round-robin over the other requesters:
  - another requester is high -> GAP, or directly a new HOLD for it if GAP_CYCLES = 0;
  - only the owner still requests -> EXTEND;
  - nobody requests -> IDLE, grant = 0.
- EXTEND:
  - The owner keeps the LED with colour tracking.
  - Every cycle, if any other req rises -> GAP; if the owner drops req -> IDLE.
  - If both events occur in the same cycle, GAP wins.
- GAP:
  - grant = 0, busy = 0, RGB dark for exactly GAP_CYCLES cycles.
  - The pending winner is re-evaluated by round-robin on the last gap cycle; if no req is high then, go to IDLE.
- Simultaneous requests are resolved only by the round-robin pointer; there is no fixed priority.
- PWM:
  - Free-running PWM_BITS counter, cleared by reset.
  - pwm_on = (pwm_cnt < brightness), except brightness all-ones forces pwm_on = 1.
  - RGB_x = shown_colour[x] & pwm_on & (state is HOLD or EXTEND).
  - All RGB outputs are registered.
- Widths:
  - Hold/gap counter is $clog2(max(HOLD_CYCLES, GAP_CYCLES)+1) bits and never wraps inside a state.
  - rr pointer is $clog2(NUM_REQ) bits with explicit wrap at NUM_REQ-1.

Decomposition:
- Shared package rgb_pkg holds:
  - bgr colour constants RED = 3'b001, GREEN = 3'b010, BLUE = 3'b100, plus OFF/WHITE;
  - arb_state_t enum {IDLE, HOLD, EXTEND, GAP}.
- One sub-module, rgb_pwm: PWM counter and gating of a 3-bit colour. Its ports are clk, rst, brightness, color_in, enable, and RGB_R/G/B.

Test Plan:
All scenarios use NUM_REQ=4, HOLD_CYCLES=8, GAP_CYCLES=2, PWM_BITS=4, brightness=4'hF unless stated.
1. Reset then req=0000 -> grant=0000, busy=0, RGB=000 indefinitely; assert rst mid-HOLD -> all outputs 0 the next cycle.
2. req=0001 at cycle 0 with colour GREEN, held -> grant=0001 at cycle 1, RGB_G=1, EXTEND after 8 cycles; drop req -> IDLE and dark the next cycle.
3. req=0001 for 1 cycle only, colour RED -> RED shown for exactly 8 cycles, then IDLE with grant=0000.
4. req=1111 constant, colours R, G, B, white -> grants 0001, 0010, 0100, 1000, 0001 in turn; each lasts 8 cycles separated by 2 dark cycles.
5. Owner 2 in EXTEND; req[0] rises on the same cycle req[2] falls -> GAP (2 dark cycles) -> grant=0001.
6. brightness=4'h4, single owner BLUE -> RGB_B high 4 of every 16 cycles; brightness=0 -> RGB_B never high while busy=1.
